// File: rtl/eeprom_cmd_sched.sv
// rtl/eeprom_cmd_sched.sv - command scheduler in front of the IIC EEPROM master
//
// Buffers byte read/write requests in a DEPTH-entry FIFO and issues them to the
// EEPROM master one at a time. Each command gets a one-cycle wr/rd pulse, with
// word_addr/wr_data held stable. The scheduler then waits for done, returns read
// data on a response strobe, and flags a missing done with a timeout pulse.
//
// Optional feature macro: EEPROM_TWR_WAIT_EN
//   When defined, a write's done is followed by TWR_CYC idle cycles before the
//   next issue. This covers the EEPROM internal write cycle.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready = FIFO not full)
//   cmd_rw, cmd_addr, cmd_wdata     1 = read / 0 = write, word address, write byte
//   rsp_valid, rsp_addr, rsp_data   one-cycle read completion strobe with payload
//   tout                            one-cycle pulse, done missing for TIMEOUT_CYC
//   busy, level                     activity flag, FIFO occupancy
//   word_addr, wr_data, wr, rd      request to the master
//   rd_data, done                   completion from the master

module eeprom_cmd_sched #(
   parameter int DEPTH       = 4,
   parameter int AW          = 2,
   parameter int TWR_CYC     = 250_000,
   parameter int TIMEOUT_CYC = 16_384,
   parameter int CW          = 18
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_rw,
   input  logic [15:0]   cmd_addr,
   input  logic [7:0]    cmd_wdata,
   output logic          rsp_valid,
   output logic [15:0]   rsp_addr,
   output logic [7:0]    rsp_data,
   output logic          tout,
   output logic          busy,
   output logic [AW:0]   level,
   output logic [15:0]   word_addr,
   output logic [7:0]    wr_data,
   output logic          wr,
   output logic          rd,
   input  logic [7:0]    rd_data,
   input  logic          done
);

   // The shared counter must be able to reach the last cycle of either wait.
   if ((TWR_CYC > (1 << CW)) || (TIMEOUT_CYC > (1 << CW))) begin : g_cw_check
      $error("eeprom_cmd_sched: CW too narrow for TWR_CYC/TIMEOUT_CYC");
   end

   typedef enum logic [1:0] {
      S_IDLE
      , S_WAIT_DONE
`ifdef EEPROM_TWR_WAIT_EN
      , S_TWR_WAIT
`endif
   } state_t;

   // FIFO entry layout: {rw, addr[15:0], wdata[7:0]}
   localparam int EW = 25;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
`ifdef EEPROM_TWR_WAIT_EN
   localparam logic [CW-1:0] TWR_LAST = CW'(TWR_CYC - 1);
`endif

   state_t          state_q, state_d;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [EW-1:0]   mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            op_rd_q, op_rd_d;
   logic [15:0]     word_addr_q, word_addr_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic            wr_q, wr_d;
   logic            rd_q, rd_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [15:0]     rsp_addr_q, rsp_addr_d;
   logic [7:0]      rsp_data_q, rsp_data_d;
   logic            tout_q, tout_d;

   logic            push;
   logic            pop;
   logic [EW-1:0]   head;

   assign cmd_ready = (count_q != (AW+1)'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      op_rd_d     = op_rd_q;
      word_addr_d = word_addr_q;
      wr_data_d   = wr_data_q;
      rsp_addr_d  = rsp_addr_q;
      rsp_data_d  = rsp_data_q;
      wr_d        = 1'b0;
      rd_d        = 1'b0;
      rsp_valid_d = 1'b0;
      tout_d      = 1'b0;
      pop         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop         = 1'b1;
               word_addr_d = head[23:8];
               wr_data_d   = head[7:0];
               op_rd_d     = head[24];
               rd_d        = head[24];
               wr_d        = !head[24];
               cnt_d       = '0;
               state_d     = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            // done is checked first so it wins over the timeout limit
            if (done) begin
               if (op_rd_q) begin
                  rsp_data_d  = rd_data;
                  rsp_addr_d  = word_addr_q;
                  rsp_valid_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
`ifdef EEPROM_TWR_WAIT_EN
                  cnt_d   = '0;
                  state_d = S_TWR_WAIT;
`else
                  state_d = S_IDLE;
`endif
               end
            end else if (cnt_q == TO_LAST) begin
               // The command is dropped; the master has to be reset upstream.
               tout_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef EEPROM_TWR_WAIT_EN
         S_TWR_WAIT: begin
            if (cnt_q == TWR_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = {cmd_rw, cmd_addr, cmd_wdata};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cnt_q       <= '0;
         op_rd_q     <= 1'b0;
         word_addr_q <= '0;
         wr_data_q   <= '0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_addr_q  <= '0;
         rsp_data_q  <= '0;
         tout_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cnt_q       <= cnt_d;
         op_rd_q     <= op_rd_d;
         word_addr_q <= word_addr_d;
         wr_data_q   <= wr_data_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_addr_q  <= rsp_addr_d;
         rsp_data_q  <= rsp_data_d;
         tout_q      <= tout_d;
      end
   end

   assign busy      = (state_q != S_IDLE) || (count_q != '0);
   assign level     = count_q;
   assign word_addr = word_addr_q;
   assign wr_data   = wr_data_q;
   assign wr        = wr_q;
   assign rd        = rd_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_addr  = rsp_addr_q;
   assign rsp_data  = rsp_data_q;
   assign tout      = tout_q;

endmodule

// File: tb/tb_eeprom_cmd_sched.sv
// tb/tb_eeprom_cmd_sched.sv - directed self-checking bench for eeprom_cmd_sched

module tb_eeprom_cmd_sched;

   localparam int TWR = 12;
   localparam int TMO = 20;
`ifdef EEPROM_TWR_WAIT_EN
   localparam int GAP       = TWR + 1;
   localparam int BUSY_WDON = 1;
`else
   localparam int GAP       = 2;
   localparam int BUSY_WDON = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_rw;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_addr;
   logic [7:0]  rsp_data;
   logic        tout;
   logic        busy;
   logic [2:0]  level;
   logic [15:0] word_addr;
   logic [7:0]  wr_data;
   logic        wr;
   logic        rd;
   logic [7:0]  rd_data;
   logic        done;

   int total = 0;
   int bad   = 0;
   int n;

   eeprom_cmd_sched #(
      .DEPTH(4), .AW(2), .TWR_CYC(TWR), .TIMEOUT_CYC(TMO), .CW(18)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
      .tout(tout), .busy(busy), .level(level),
      .word_addr(word_addr), .wr_data(wr_data), .wr(wr), .rd(rd),
      .rd_data(rd_data), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic rw, input logic [15:0] a, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; rd_data = '0; done = 1'b0;
      tick(); tick();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_level", level, 0);
      chk("rst_wr_rd", {wr, rd, rsp_valid, tout, busy}, 0);
      chk("rst_word_addr", word_addr, 0);
      rst_n = 1'b1;
      tick();

      // Write 0x0123 <- 0x5A
      offer(1'b0, 16'h0123, 8'h5A);
      tick();
      cmd_valid = 1'b0;
      chk("wr_push_level", level, 1);
      chk("wr_not_yet", wr, 0);
      tick();
      chk("wr_pulse", {wr, rd}, 2'b10);
      chk("wr_addr", word_addr, 16'h0123);
      chk("wr_data", wr_data, 8'h5A);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wr_pulse_gone", {wr, rd}, 2'b00);
         chk("wr_hold", {word_addr, wr_data}, {16'h0123, 8'h5A});
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("wr_done_busy", busy, BUSY_WDON);

      // Read 0x0040 queued right after the write completes; measure the gap
      offer(1'b1, 16'h0040, 8'h00);
      tick();
      cmd_valid = 1'b0;
      n = 1;
      while (rd !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("issue_gap_after_write", n, GAP);
      chk("rd_addr", word_addr, 16'h0040);
      chk("rd_no_wr", wr, 0);
      tick();
      chk("rd_pulse_gone", rd, 0);
      done = 1'b1; rd_data = 8'hC3;
      tick();
      done = 1'b0; rd_data = 8'h00;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, 8'hC3);
      chk("rsp_addr", rsp_addr, 16'h0040);
      tick();
      chk("rsp_valid_1cyc", rsp_valid, 0);
      chk("rsp_data_hold", rsp_data, 8'hC3);

      // Five back-to-back reads: one issues, four fill the FIFO
      for (int i = 0; i < 5; i++) begin
         offer(1'b1, 16'h0100 + 16'(i), 8'h00);
         tick();
      end
      chk("full_level", level, 4);
      chk("full_ready", cmd_ready, 0);
      offer(1'b1, 16'h0199, 8'h00);
      tick();
      cmd_valid = 1'b0;
      chk("full_no_push", level, 4);
      chk("first_issued", word_addr, 16'h0100);
      for (int i = 0; i < 5; i++) begin
         done = 1'b1; rd_data = 8'h10 + 8'(i);
         tick();
         done = 1'b0;
         chk("fifo_rsp_addr", rsp_addr, 16'h0100 + 16'(i));
         chk("fifo_rsp_data", {rsp_valid, rsp_data}, {1'b1, 8'h10 + 8'(i)});
         if (i < 4) begin
            tick();
            chk("fifo_order", {rd, word_addr}, {1'b1, 16'h0100 + 16'(i + 1)});
         end
      end
      chk("drained", {busy, level}, 4'h0);
      chk("ready_again", cmd_ready, 1);

      // Timeout: read 0x0AAA never completes, read 0x0BBB is queued behind it
      offer(1'b1, 16'h0AAA, 8'h00);
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("to_issue", {rd, word_addr}, {1'b1, 16'h0AAA});
      offer(1'b1, 16'h0BBB, 8'h00);
      tick();
      cmd_valid = 1'b0;
      n = 1;
      while (tout !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("tout_latency", n, TMO);
      chk("tout_no_rsp", rsp_valid, 0);
      tick();
      chk("tout_1cyc", tout, 0);
      chk("after_tout_issue", {rd, word_addr}, {1'b1, 16'h0BBB});

      // Push during the pop cycle at level 2
      offer(1'b1, 16'h0300, 8'h00);
      tick();
      offer(1'b0, 16'h0301, 8'h3C);
      tick();
      cmd_valid = 1'b0;
      chk("lvl2_before", level, 2);
      done = 1'b1; rd_data = 8'h5E;
      tick();
      done = 1'b0;
      chk("lvl2_rsp", {rsp_valid, rsp_addr, rsp_data}, {1'b1, 16'h0BBB, 8'h5E});
      offer(1'b1, 16'h0302, 8'h00);
      tick();
      cmd_valid = 1'b0;
      chk("lvl2_push_pop", level, 2);
      chk("lvl2_issue", {rd, word_addr}, {1'b1, 16'h0300});

      // Reset while the read to 0x0300 waits for done
      rst_n = 1'b0;
      #1;
      chk("async_rst_rd", {wr, rd}, 2'b00);
      chk("async_rst_level", level, 0);
      chk("async_rst_ready", cmd_ready, 1);
      done = 1'b1; rd_data = 8'hEE;
      tick(); tick();
      chk("rst_no_rsp", rsp_valid, 0);
      rst_n = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flushed_no_issue", {wr, rd, rsp_valid}, 3'b000);
         chk("flushed_idle", {busy, level}, 4'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
